// File: rtl/midi_msg_assembler.sv
// MIDI 8N1 receiver and channel-voice message assembler with running status.
// Optional MIDI_CHANNEL_FILTER_EN restricts emitted messages to CHANNEL.
module midi_msg_assembler #(
  parameter int          CLKS_PER_BIT = 3200,
  parameter logic [3:0]  CHANNEL      = 4'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        midi_in,
  output logic [23:0] msg,
  output logic        new_msg,
  output logic        frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP, BRK
  } uart_t;

  uart_t          st, st_n;
  logic           s1, s2;
  logic [CW-1:0]  cnt, cnt_n;
  logic [2:0]     bit_i, bit_n;
  logic [7:0]     sh, sh_n;
  logic           byte_stb, stop_bad;

  logic [7:0]     rs, rs_n;
  logic           rs_v, rs_v_n;
  logic           two, two_n;
  logic           idx, idx_n;
  logic [7:0]     d1, d1_n;
  logic [23:0]    msg_n;
  logic           new_n;
  logic           emit_ok;

  logic is_rt, is_sys, is_stat, is_dat;

`ifdef MIDI_CHANNEL_FILTER_EN
  assign emit_ok = (rs[3:0] == CHANNEL);
`else
  logic unused_ch;
  assign unused_ch = ^CHANNEL;
  assign emit_ok   = 1'b1;
`endif

  // Two-flop synchroniser on the async line, idle high
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= midi_in;
      s2 <= s1;
    end
  end

  // UART and parser state registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      st        <= IDLE;
      cnt       <= '0;
      bit_i     <= '0;
      sh        <= '0;
      rs        <= '0;
      rs_v      <= 1'b0;
      two       <= 1'b0;
      idx       <= 1'b0;
      d1        <= '0;
      msg       <= '0;
      new_msg   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      bit_i     <= bit_n;
      sh        <= sh_n;
      rs        <= rs_n;
      rs_v      <= rs_v_n;
      two       <= two_n;
      idx       <= idx_n;
      d1        <= d1_n;
      msg       <= msg_n;
      new_msg   <= new_n;
      frame_err <= stop_bad;
    end
  end

  // UART next state: mid-bit sampling, stop check, wait out a break
  always_comb begin
    st_n     = st;
    cnt_n    = cnt;
    bit_n    = bit_i;
    sh_n     = sh;
    byte_stb = 1'b0;
    stop_bad = 1'b0;
    unique case (st)
      IDLE: begin
        if (!s2) begin
          st_n  = START;
          cnt_n = '0;
        end
      end
      START: begin
        if (cnt == HALF) begin
          cnt_n = '0;
          bit_n = '0;
          st_n  = s2 ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          sh_n  = {s2, sh[7:1]};
          if (bit_i == 3'd7) st_n = STOP;
          else bit_n = bit_i + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == FULL) begin
          cnt_n = '0;
          if (s2) begin
            byte_stb = 1'b1;
            st_n     = IDLE;
          end else begin
            stop_bad = 1'b1;
            st_n     = BRK;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      BRK: begin
        if (s2) st_n = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  assign is_rt   = &sh[7:3];
  assign is_sys  = (sh[7:4] == 4'hF) && !sh[3];
  assign is_stat = sh[7] && (sh[7:4] != 4'hF);
  assign is_dat  = !sh[7];

  // Parser: running status, data collection and message emit
  always_comb begin
    rs_n   = rs;
    rs_v_n = rs_v;
    two_n  = two;
    idx_n  = idx;
    d1_n   = d1;
    msg_n  = msg;
    new_n  = 1'b0;
    if (byte_stb) begin
      unique case (1'b1)
        is_rt: ;
        is_sys: begin
          rs_v_n = 1'b0;
          idx_n  = 1'b0;
        end
        is_stat: begin
          rs_n   = sh;
          rs_v_n = 1'b1;
          two_n  = (sh[7:5] != 3'b110);
          idx_n  = 1'b0;
        end
        is_dat && !rs_v: ;
        is_dat && rs_v: begin
          if (!idx) begin
            d1_n = sh;
            if (two) begin
              idx_n = 1'b1;
            end else begin
              new_n = emit_ok;
              if (emit_ok) msg_n = {8'h00, sh, rs};
            end
          end else begin
            idx_n = 1'b0;
            new_n = emit_ok;
            if (emit_ok) msg_n = {sh, d1, rs};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_midi_msg_assembler.sv
// Directed bench for midi_msg_assembler at 16 clocks per bit.
// Byte sequences in a table, plus glitch and reset sequences.
module tb_midi_msg_assembler;

  localparam int CPB = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        midi_in = 1'b1;
  logic [23:0] msg;
  logic        new_msg;
  logic        frame_err;

  int errors = 0;
  int checks = 0;

  logic [23:0] got [$];
  int          fe_cnt = 0;

  midi_msg_assembler #(
    .CLKS_PER_BIT(CPB),
    .CHANNEL     (4'd0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .midi_in  (midi_in),
    .msg      (msg),
    .new_msg  (new_msg),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (new_msg) got.push_back(msg);
    if (frame_err) fe_cnt++;
  end

  typedef struct {
    int              nb;
    logic [4:0][7:0] b;
    int              bad;
    int              en;
    logic [23:0]     ef;
    logic [23:0]     el;
    int              efe;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit good);
    midi_in = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      midi_in = b[i];
      repeat (CPB) @(posedge clk);
    end
    midi_in = good;
    repeat (CPB) @(posedge clk);
    midi_in = 1'b1;
    if (!good) repeat (CPB) @(posedge clk);
  endtask

  logic [23:0] hold;
  int          base, fbase;

  initial begin
    vt[0]  = '{3, {8'h00, 8'h00, 8'h40, 8'h40, 8'hB0}, -1, 1,
               24'h4040B0, 24'h4040B0, 0};
    vt[1]  = '{5, {8'h00, 8'h3C, 8'h40, 8'h3C, 8'h90}, -1, 2,
               24'h403C90, 24'h003C90, 0};
    vt[2]  = '{2, {8'h00, 8'h00, 8'h00, 8'h07, 8'hC5}, -1, 1,
               24'h0007C5, 24'h0007C5, 0};
    vt[3]  = '{4, {8'h00, 8'h7F, 8'hF8, 8'h3C, 8'h90}, -1, 1,
               24'h7F3C90, 24'h7F3C90, 0};
    vt[4]  = '{1, {8'h00, 8'h00, 8'h00, 8'h00, 8'h55}, 0, 0,
               24'h0, 24'h0, 1};
    vt[5]  = '{3, {8'h00, 8'h00, 8'h00, 8'h3C, 8'h80}, -1, 1,
               24'h003C80, 24'h003C80, 0};
    vt[6]  = '{5, {8'h45, 8'hF7, 8'h34, 8'h12, 8'hF0}, -1, 0,
               24'h0, 24'h0, 0};
    vt[7]  = '{5, {8'h41, 8'h40, 8'h90, 8'h3C, 8'h91}, -1, 1,
               24'h414090, 24'h414090, 0};
    vt[8]  = '{3, {8'h00, 8'h00, 8'h21, 8'h20, 8'hD3}, -1, 2,
               24'h0020D3, 24'h0021D3, 0};
    vt[9]  = '{5, {8'h20, 8'hFA, 8'h10, 8'hFF, 8'h99}, -1, 1,
               24'h201099, 24'h201099, 0};
`ifdef MIDI_CHANNEL_FILTER_EN
    vt[10] = '{3, {8'h00, 8'h00, 8'h40, 8'h3C, 8'h91}, -1, 0,
               24'h0, 24'h0, 0};
`else
    vt[10] = '{3, {8'h00, 8'h00, 8'h40, 8'h3C, 8'h91}, -1, 1,
               24'h403C91, 24'h403C91, 0};
`endif

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rst_msg", 32'(msg), 32'h0);
    chk("rst_new", 32'(new_msg), 32'h0);
    chk("rst_fe", 32'(frame_err), 32'h0);
    reset = 1'b1;
    repeat (4) @(posedge clk);

    hold = 24'h0;
    for (int v = 0; v < 11; v++) begin
      base  = got.size();
      fbase = fe_cnt;
      for (int k = 0; k < vt[v].nb; k++)
        send_byte(vt[v].b[k], k != vt[v].bad);
      repeat (40) @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_count", v), 32'(got.size() - base),
          32'(vt[v].en));
      chk($sformatf("v%0d_ferr", v), 32'(fe_cnt - fbase),
          32'(vt[v].efe));
      if (vt[v].en > 0 && got.size() - base == vt[v].en) begin
        chk($sformatf("v%0d_first", v), 32'(got[base]), 32'(vt[v].ef));
        chk($sformatf("v%0d_last", v), 32'(got[got.size() - 1]),
            32'(vt[v].el));
        hold = vt[v].el;
      end
      chk($sformatf("v%0d_hold", v), 32'(msg), 32'(hold));
    end

    base = got.size();
    midi_in = 1'b0;
    repeat (3) @(posedge clk);
    midi_in = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("glitch_none", 32'(got.size() - base), 32'h0);
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h40, 1'b1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("glitch_after_cnt", 32'(got.size() - base), 32'h1);
    chk("glitch_after_msg", 32'(msg), 32'h403C90);

    base = got.size();
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_msg", 32'(msg), 32'h0);
    send_byte(8'h40, 1'b1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("rst_lost_rs", 32'(got.size() - base), 32'h0);
    send_byte(8'h90, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'h40, 1'b1);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("rst_after_cnt", 32'(got.size() - base), 32'h1);
    chk("rst_after_msg", 32'(msg), 32'h403C90);
    chk("total_fe", 32'(fe_cnt), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
